// File: rtl/mag_window_stats.sv
// mag_window_stats: per-window statistics over N = 2**WIN_LOG2 accepted samples
// of a 7-bit unsigned magnitude stream (sum, peak, over-threshold count and
// saturated-sample count), presented with a one-cycle out_valid strobe.
// Optional feature: define WINDOW_MIN_EN to add out_min (window minimum).
module mag_window_stats #(
    parameter int         WIN_LOG2 = 4,
    parameter logic [6:0] THRESH   = 7'd100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [6:0]            in_mag,
    output logic                  out_valid,
    output logic [7+WIN_LOG2-1:0] out_sum,
    output logic [6:0]            out_max,
    output logic [WIN_LOG2:0]     out_over_cnt,
    output logic [WIN_LOG2:0]     out_sat_cnt,
`ifdef WINDOW_MIN_EN
    output logic [6:0]            out_min,
`endif
    output logic                  busy
);

    localparam int SW = 7 + WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [WIN_LOG2-1:0] LAST_IDX = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] ONE_IDX  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [WIN_LOG2-1:0] cnt, cnt_nxt;
    logic [SW-1:0]       sum_acc, sum_nxt;
    logic [6:0]          max_acc, max_nxt;
    logic [CW-1:0]       over_acc, over_nxt;
    logic [CW-1:0]       sat_acc, sat_nxt;
`ifdef WINDOW_MIN_EN
    logic [6:0]          min_acc, min_nxt;
`endif
    logic                accept;
    logic                first;
    logic                done;

    // Next-state, sample counter and accumulator update for one accepted sample.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sum_nxt   = sum_acc;
        max_nxt   = max_acc;
        over_nxt  = over_acc;
        sat_nxt   = sat_acc;
`ifdef WINDOW_MIN_EN
        min_nxt   = min_acc;
`endif
        accept = in_valid & ~clear;
        // In IDLE the accumulators may hold stale values from an aborted
        // window; the first sample of a window always restarts them.
        first  = (state == IDLE);
        done   = accept & (state == ACCUM) & (cnt == LAST_IDX);

        if (accept) begin
            sum_nxt  = (first ? {SW{1'b0}} : sum_acc) + {{(SW-7){1'b0}}, in_mag};
            max_nxt  = (first || (in_mag > max_acc)) ? in_mag : max_acc;
            over_nxt = (first ? {CW{1'b0}} : over_acc)
                     + {{(CW-1){1'b0}}, (in_mag >= THRESH)};
            sat_nxt  = (first ? {CW{1'b0}} : sat_acc)
                     + {{(CW-1){1'b0}}, (in_mag == 7'd127)};
`ifdef WINDOW_MIN_EN
            min_nxt  = (first || (in_mag < min_acc)) ? in_mag : min_acc;
`endif
        end else begin
            sum_nxt  = sum_acc;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCUM;
                    cnt_nxt   = ONE_IDX;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCUM: begin
                if (clear) begin
                    state_nxt = IDLE;
                    cnt_nxt   = {WIN_LOG2{1'b0}};
                end else if (done) begin
                    state_nxt = IDLE;
                    cnt_nxt   = {WIN_LOG2{1'b0}};
                end else if (accept) begin
                    cnt_nxt   = cnt + ONE_IDX;
                end else begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = {WIN_LOG2{1'b0}};
            end
        endcase
    end

    // State, accumulators and registered outputs; results load on the Nth sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= {WIN_LOG2{1'b0}};
            sum_acc      <= {SW{1'b0}};
            max_acc      <= 7'd0;
            over_acc     <= {CW{1'b0}};
            sat_acc      <= {CW{1'b0}};
            out_valid    <= 1'b0;
            out_sum      <= {SW{1'b0}};
            out_max      <= 7'd0;
            out_over_cnt <= {CW{1'b0}};
            out_sat_cnt  <= {CW{1'b0}};
            busy         <= 1'b0;
`ifdef WINDOW_MIN_EN
            min_acc      <= 7'd0;
            out_min      <= 7'd0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sum_acc   <= sum_nxt;
            max_acc   <= max_nxt;
            over_acc  <= over_nxt;
            sat_acc   <= sat_nxt;
            out_valid <= done;
            busy      <= (state_nxt == ACCUM);
`ifdef WINDOW_MIN_EN
            min_acc   <= min_nxt;
`endif
            if (done) begin
                out_sum      <= sum_nxt;
                out_max      <= max_nxt;
                out_over_cnt <= over_nxt;
                out_sat_cnt  <= sat_nxt;
`ifdef WINDOW_MIN_EN
                out_min      <= min_nxt;
`endif
            end else begin
                out_sum      <= out_sum;
            end
        end
    end

endmodule

// File: tb/tb_mag_window_stats.sv
// Self-checking bench for mag_window_stats (WIN_LOG2=4, THRESH=100): directed
// scenarios followed by randomized traffic, compared every cycle against a
// queue-based window model. Checks out_min too when WINDOW_MIN_EN is defined.
module tb_mag_window_stats;

    localparam int WL = 4;
    localparam int N  = 16;
    localparam int TH = 100;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [6:0]    in_mag;
    logic          out_valid;
    logic [10:0]   out_sum;
    logic [6:0]    out_max;
    logic [4:0]    out_over_cnt;
    logic [4:0]    out_sat_cnt;
    logic          busy;
`ifdef WINDOW_MIN_EN
    logic [6:0]    out_min;
`endif

    mag_window_stats #(.WIN_LOG2(WL), .THRESH(7'd100)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_mag       (in_mag),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_max      (out_max),
        .out_over_cnt (out_over_cnt),
        .out_sat_cnt  (out_sat_cnt),
`ifdef WINDOW_MIN_EN
        .out_min      (out_min),
`endif
        .busy         (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state: samples of the current partial window.
    int q_win[$];
    int e_valid, e_sum, e_max, e_min, e_over, e_sat, e_busy;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model reaction to one clock edge with the given inputs.
    task automatic model_edge(input bit v, input int m, input bit c, input bit r);
        e_valid = 0;
        if (!r) begin
            q_win.delete();
            e_sum = 0; e_max = 0; e_min = 0; e_over = 0; e_sat = 0;
        end else if (c) begin
            q_win.delete();
        end else if (v) begin
            q_win.push_back(m);
            if (q_win.size() == N) begin
                e_valid = 1;
                e_sum = 0; e_max = 0; e_min = 127; e_over = 0; e_sat = 0;
                foreach (q_win[i]) begin
                    e_sum += q_win[i];
                    if (q_win[i] > e_max) e_max = q_win[i];
                    if (q_win[i] < e_min) e_min = q_win[i];
                    if (q_win[i] >= TH) e_over++;
                    if (q_win[i] == 127) e_sat++;
                end
                q_win.delete();
            end
        end
        e_busy = (q_win.size() > 0) ? 1 : 0;
    endtask

    // Apply one cycle of inputs (from a negedge), then compare on the next negedge.
    task automatic step(input bit v, input int m, input bit c, input bit r);
        in_valid = v;
        in_mag   = m[6:0];
        clear    = c;
        reset    = r;
        @(posedge clk);
        model_edge(v, m, c, r);
        @(negedge clk);
        check("out_valid", int'(out_valid), e_valid);
        check("out_sum", int'(out_sum), e_sum);
        check("out_max", int'(out_max), e_max);
        check("out_over_cnt", int'(out_over_cnt), e_over);
        check("out_sat_cnt", int'(out_sat_cnt), e_sat);
        check("busy", int'(busy), e_busy);
`ifdef WINDOW_MIN_EN
        check("out_min", int'(out_min), e_min);
`endif
    endtask

    task automatic burst(input int cnt, input int m);
        for (int i = 0; i < cnt; i++) step(1'b1, m, 1'b0, 1'b1);
    endtask

    initial begin
        int m;
        bit v, c, r;
        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mag = 7'd0;
        e_sum = 0; e_max = 0; e_min = 0; e_over = 0; e_sat = 0; e_valid = 0; e_busy = 0;
        @(negedge clk);

        // Reset state.
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);

        // 16 x 5.
        burst(N, 5);
        check("plan_const_sum", int'(out_sum), 80);
        check("plan_const_max", int'(out_max), 5);
        step(1'b0, 0, 1'b0, 1'b1);

        // Ramp 0..15 with in_valid toggling.
        for (int i = 0; i < N; i++) begin
            step(1'b1, i, 1'b0, 1'b1);
            if (i != N - 1) step(1'b0, 77, 1'b0, 1'b1);
        end
        check("plan_ramp_sum", int'(out_sum), 120);
        check("plan_ramp_max", int'(out_max), 15);

        // 16 x 127.
        burst(N, 127);
        check("plan_sat_sum", int'(out_sum), 2032);
        check("plan_sat_cnt", int'(out_sat_cnt), 16);

        // 7 x 50, clear with valid, 16 x 1.
        burst(7, 50);
        step(1'b1, 50, 1'b1, 1'b1);
        burst(N, 1);
        check("plan_clear_sum", int'(out_sum), 16);

        // 15 samples, then clear on the Nth sample.
        burst(15, 9);
        step(1'b1, 9, 1'b1, 1'b1);
        check("plan_clear_nth_keep", int'(out_sum), 16);

        // Back-to-back windows 16 x 99 then 16 x 100.
        burst(N, 99);
        check("plan_b2b_sum1", int'(out_sum), 1584);
        burst(N, 100);
        check("plan_b2b_over2", int'(out_over_cnt), 16);

        // Reset mid-window, then 16 x 3.
        burst(10, 7);
        step(1'b1, 7, 1'b0, 1'b0);
        burst(N, 3);
        check("plan_rst_sum", int'(out_sum), 48);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < 75);
            c = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 999) >= 3);
            case ($urandom_range(0, 7))
                0:       m = 127;
                1:       m = 100;
                2:       m = 99;
                3:       m = 0;
                default: m = int'($urandom_range(0, 127));
            endcase
            step(v, m, c, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
